// File: rtl/conv_bias_stream.sv
// Bias streamer: per-channel bias array with a write port, streamed to the
// MAC accumulators over valid/ready. Each bias is presented REPEAT beats
// before advancing to the next channel of the window.
//
// state | meaning
// IDLE  | waiting for start; array writes accepted
// RUN   | fetching and streaming the channel window
// FIN   | one-cycle done pulse, then back to IDLE
module conv_bias_stream #(
  parameter int BIAS_W = 32,
  parameter int N_CH   = 32,
  parameter int ADDR_W = 5,
  parameter int REPEAT = 3
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BIAS_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] ch_base,
  input  logic [ADDR_W:0]   ch_count,
  output logic [BIAS_W-1:0] bias_out,
  output logic              bias_valid,
  input  logic              bias_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int RPT_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT - 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
  localparam logic [ADDR_W:0]  N_CH_C   = (ADDR_W + 1)'(N_CH);
  localparam logic [ADDR_W:0]  IDX_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;

  logic [BIAS_W-1:0] mem [N_CH];
  logic [BIAS_W-1:0] rd_data, buf_data, out_data;
  logic              rd_pend, buf_v, out_v;
  logic [ADDR_W-1:0] base_q, rd_addr;
  logic [ADDR_W:0]   cnt_q, fetch_idx, pop_idx;
  logic [RPT_W-1:0]  rpt_q;
  logic              err_q, zero_done_q;
  logic              accept, pop, last_pop, issue, out_free;
  logic              idle_start, start_ok, start_zero, start_bad, wr_ok;
  logic [1:0]        occ;

  assign idle_start = (state_q == IDLE) && start;
  assign start_ok   = idle_start && (ch_count != '0) && (ch_count <= N_CH_C);
  assign start_zero = idle_start && (ch_count == '0);
  assign start_bad  = idle_start && (ch_count > N_CH_C);
  assign wr_ok      = wr_en && (state_q != RUN);

  assign accept   = out_v && bias_ready;
  assign pop      = accept && (rpt_q == RPT_LAST);
  assign last_pop = pop && (pop_idx == (cnt_q - IDX_ONE));
  assign out_free = !out_v || pop;

  // A read may only be issued if its data is guaranteed a slot (output or
  // prefetch buffer) when it lands next cycle, counting this cycle's pop.
  assign occ     = {1'b0, out_v} + {1'b0, buf_v} + {1'b0, rd_pend};
  assign issue   = (state_q == RUN) && (fetch_idx < cnt_q) && (occ <= ({1'b0, pop} + 2'd1));
  assign rd_addr = base_q + fetch_idx[ADDR_W-1:0];

  assign bias_out   = out_data;
  assign bias_valid = out_v;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == FIN) || zero_done_q;
  assign err        = err_q;

  // Bias array: synchronous read, read-before-write on address collision.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (issue) rd_data <= mem[rd_addr];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (last_pop) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window counters, fetch pipeline, prefetch buffer and output stage.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rd_pend     <= 1'b0;
      buf_v       <= 1'b0;
      out_v       <= 1'b0;
      buf_data    <= '0;
      out_data    <= '0;
      rpt_q       <= '0;
      fetch_idx   <= '0;
      pop_idx     <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= start_zero;
      rd_pend     <= issue;

      if (start_ok)                                   err_q <= 1'b0;
      else if (start_bad || (wr_en && state_q == RUN)) err_q <= 1'b1;

      if (start_ok) begin
        base_q    <= ch_base;
        cnt_q     <= ch_count;
        fetch_idx <= '0;
        pop_idx   <= '0;
        rpt_q     <= '0;
      end else begin
        if (issue) fetch_idx <= fetch_idx + IDX_ONE;
        if (accept) rpt_q <= pop ? '0 : rpt_q + RPT_ONE;
        if (pop) pop_idx <= pop_idx + IDX_ONE;
      end

      if (out_free) begin
        if (buf_v) begin
          out_data <= buf_data;
          out_v    <= 1'b1;
          buf_v    <= rd_pend;
          if (rd_pend) buf_data <= rd_data;
        end else if (rd_pend) begin
          out_data <= rd_data;
          out_v    <= 1'b1;
        end else begin
          out_v <= 1'b0;
        end
      end else if (rd_pend) begin
        buf_data <= rd_data;
        buf_v    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_bias_stream.sv
// Bench for conv_bias_stream: one REPEAT=3 and one REPEAT=1 instance share
// all inputs; each has its own expected-beat queue checked on acceptance.
module tb_conv_bias_stream;

  logic        clk = 1'b0;
  logic        rst_b, wr_en, start, bias_ready;
  logic [4:0]  wr_addr, ch_base;
  logic [31:0] wr_data;
  logic [5:0]  ch_count;
  logic [31:0] b3, b1;
  logic        v3, busy3, done3, err3;
  logic        v1, busy1, done1, err1;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt3 = 0;
  int done_cnt1 = 0;
  logic [31:0] mem_m [32];
  logic [31:0] q3 [$];
  logic [31:0] q1 [$];
  logic        hold3 = 1'b0, hold1 = 1'b0;
  logic [31:0] hold3_val, hold1_val;

  always #5 clk = ~clk;

  conv_bias_stream #(.BIAS_W(32), .N_CH(32), .ADDR_W(5), .REPEAT(3)) u_r3 (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .ch_base(ch_base), .ch_count(ch_count), .bias_out(b3),
    .bias_valid(v3), .bias_ready(bias_ready), .busy(busy3), .done(done3), .err(err3));

  conv_bias_stream #(.BIAS_W(32), .N_CH(32), .ADDR_W(5), .REPEAT(1)) u_r1 (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .ch_base(ch_base), .ch_count(ch_count), .bias_out(b1),
    .bias_valid(v1), .bias_ready(bias_ready), .busy(busy1), .done(done1), .err(err1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stall-stability monitor for both instances.
  always @(negedge clk) begin
    if (!rst_b) begin
      hold3 = 1'b0;
      hold1 = 1'b0;
    end else begin
      if (hold3) check("stall_hold3", {v3, b3}, {1'b1, hold3_val});
      if (hold1) check("stall_hold1", {v1, b1}, {1'b1, hold1_val});
      hold3 = v3 && !bias_ready;
      hold3_val = b3;
      hold1 = v1 && !bias_ready;
      hold1_val = b1;
      if (done3) done_cnt3++;
      if (done1) done_cnt1++;
      if (v3 && bias_ready) begin
        if (q3.size() == 0) check("extra_beat3", 1, 0);
        else check("beat3", b3, q3.pop_front());
      end
      if (v1 && bias_ready) begin
        if (q1.size() == 0) check("extra_beat1", 1, 0);
        else check("beat1", b1, q1.pop_front());
      end
    end
  end

  task automatic run_window(input int base, input int cnt, input bit stall,
                            input bit wr_mid, input bit exp_err);
    int cyc, fv3, fv1, dc3, dc1, bub3, bub1, bb3, bb1, d0_3, d0_1;
    for (int i = 0; i < cnt; i++) begin
      for (int r = 0; r < 3; r++) q3.push_back(mem_m[(base + i) % 32]);
      q1.push_back(mem_m[(base + i) % 32]);
    end
    d0_3 = done_cnt3;
    d0_1 = done_cnt1;
    start = 1'b1;
    ch_base = 5'(base);
    ch_count = 6'(cnt);
    bias_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; fv3 = -1; fv1 = -1; dc3 = -1; dc1 = -1;
    bub3 = 0; bub1 = 0; bb3 = 0; bb1 = 0;
    while ((dc3 < 0 || dc1 < 0) && cyc < 400) begin
      bias_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      wr_en = wr_mid && (cyc == 3);
      wr_addr = 5'd5;
      wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      if (dc3 < 0) begin
        if (done3) dc3 = cyc;
        else begin
          if (!busy3) bb3++;
          if (fv3 < 0 && v3) fv3 = cyc;
          else if (fv3 >= 0 && !v3) bub3++;
        end
      end
      if (dc1 < 0) begin
        if (done1) dc1 = cyc;
        else begin
          if (!busy1) bb1++;
          if (fv1 < 0 && v1) fv1 = cyc;
          else if (fv1 >= 0 && !v1) bub1++;
        end
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    bias_ready = 1'b1;
    check("done3_seen", dc3 >= 0, 1);
    check("done1_seen", dc1 >= 0, 1);
    check("q3_drained", q3.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("busy3_low_in_run", bb3, 0);
    check("busy1_low_in_run", bb1, 0);
    check("done3_pulses", done_cnt3 - d0_3, 1);
    check("done1_pulses", done_cnt1 - d0_1, 1);
    check("err3", err3, exp_err);
    check("err1", err1, exp_err);
    check("busy3_after", busy3, 0);
    if (!stall) begin
      check("latency3", fv3, 2);
      check("latency1", fv1, 2);
      check("done3_cycle", dc3, 2 + 3 * cnt);
      check("done1_cycle", dc1, 2 + cnt);
      check("bubbles3", bub3, 0);
      check("bubbles1", bub1, 0);
    end
    q3.delete();
    q1.delete();
  endtask

  typedef struct {
    int base;
    int cnt;
    bit stall;
    bit wr_mid;
    bit exp_err;
  } vec_t;

  vec_t vecs[5];
  int   d0_3, d0_1;

  initial begin
    vecs[0] = '{0, 4, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{30, 4, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{0, 4, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{0, 32, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{10, 5, 1'b0, 1'b1, 1'b1};

    rst_b = 1'b0; wr_en = 1'b0; start = 1'b0; bias_ready = 1'b1;
    wr_addr = '0; wr_data = '0; ch_base = '0; ch_count = '0;
    tick();
    tick();
    @(negedge clk);
    check("rst_out3", {b3, v3, busy3, done3, err3}, 0);
    check("rst_out1", {b1, v1, busy1, done1, err1}, 0);
    rst_b = 1'b1;
    tick();

    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1;
      wr_addr = 5'(i);
      wr_data = 32'h100 + 32'(i);
      mem_m[i] = 32'h100 + 32'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();

    for (int v = 0; v < 5; v++)
      run_window(vecs[v].base, vecs[v].cnt, vecs[v].stall, vecs[v].wr_mid, vecs[v].exp_err);

    // zero-length window: done pulse only, err left as it was
    d0_3 = done_cnt3;
    d0_1 = done_cnt1;
    start = 1'b1; ch_base = 5'd7; ch_count = 6'd0;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("zero_done3", done3, 1);
    check("zero_done1", done1, 1);
    check("zero_busy3", busy3, 0);
    tick();
    @(negedge clk);
    check("zero_done3_once", done3, 0);
    check("zero_valid3", v3, 0);
    check("zero_err3_kept", err3, 1);
    check("zero_done_pulses", done_cnt3 - d0_3 + done_cnt1 - d0_1, 2);
    tick();

    // valid start clears err; window touches the address hit by the dropped write
    run_window(4, 3, 1'b1, 1'b0, 1'b0);

    // oversize window: ignored, err set
    start = 1'b1; ch_base = 5'd0; ch_count = 6'd33;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("bad_err3", err3, 1);
    check("bad_err1", err1, 1);
    check("bad_busy3", busy3, 0);
    tick();
    @(negedge clk);
    check("bad_valid3", v3, 0);
    tick();

    // reset mid-stream: immediate abort, no done
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 3; r++) q3.push_back(mem_m[i]);
      q1.push_back(mem_m[i]);
    end
    start = 1'b1; ch_base = 5'd0; ch_count = 6'd8;
    tick();
    start = 1'b0;
    repeat (5) tick();
    d0_3 = done_cnt3;
    d0_1 = done_cnt1;
    rst_b = 1'b0;
    tick();
    @(negedge clk);
    q3.delete();
    q1.delete();
    check("midrst_out3", {b3, v3, busy3, done3, err3}, 0);
    check("midrst_out1", {b1, v1, busy1, done1, err1}, 0);
    tick();
    rst_b = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("midrst_no_done", done_cnt3 - d0_3 + done_cnt1 - d0_1, 0);
    check("midrst_idle", {v3, busy3, v1, busy1}, 0);
    tick();

    run_window(28, 6, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
